// File: rtl/frequency_glide.sv
// frequency_glide: slews a phase-increment word toward a requested target.
// Each update moves by |target - frequency| >> shift (at least 1), so the
// approach is exponential with a linear tail. Updates happen every
// glide_div+1 clocks. A shift of 0 makes the first update a direct jump.
module frequency_glide #(
  parameter int FREQ_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              target_valid,
  input  logic [FREQ_W-1:0] target_freq,
  output logic              target_ready,
  input  logic [3:0]        glide_shift,
  input  logic [7:0]        glide_div,
  input  logic              hold,
  output logic [FREQ_W-1:0] frequency,
  output logic              gliding,
  output logic              settled
);

  typedef enum logic [1:0] {IDLE, LOAD, GLIDE} state_t;

  state_t            state, state_nx;
  logic [FREQ_W-1:0] tgt;
  logic [3:0]        shift_r;
  logic [7:0]        div_r;
  logic [7:0]        cnt;

  logic              accept;
  logic              up;
  logic [FREQ_W-1:0] diff;
  logic [FREQ_W-1:0] shifted;
  logic [FREQ_W-1:0] step;
  logic [FREQ_W-1:0] next_freq;
  logic              tick;
  logic              arrive;

  assign accept = target_valid && target_ready;

  // Step toward target. Magnitude is taken by subtracting the smaller
  // operand from the larger, so it never wraps; step <= diff because a
  // right shift cannot grow the value, and diff >= 1 whenever we glide,
  // so the forced minimum of 1 cannot overshoot either.
  always_comb begin
    up        = tgt > frequency;
    diff      = up ? (tgt - frequency) : (frequency - tgt);
    shifted   = diff >> shift_r;
    step      = (shifted == '0) ? {{(FREQ_W-1){1'b0}}, 1'b1} : shifted;
    next_freq = up ? (frequency + step) : (frequency - step);
    tick      = (state == GLIDE) && !hold && (cnt == div_r);
    arrive    = tick && (next_freq == tgt);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state: a fresh target always restarts through LOAD, even mid-glide.
  always_comb begin
    state_nx = state;
    if (accept) begin
      state_nx = LOAD;
    end else begin
      case (state)
        LOAD:    state_nx = (frequency != tgt) ? GLIDE : IDLE;
        GLIDE:   if (arrive) state_nx = IDLE;
        default: state_nx = state;
      endcase
    end
  end

  // Outputs decoded from state; ready is held low while reset is asserted.
  always_comb begin
    target_ready = !rst && (state != LOAD);
    gliding      = (state != IDLE);
  end

  // Datapath: capture target/config on acceptance, run the tick divider and
  // frequency updates in GLIDE, and raise a one-cycle settled pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frequency <= '0;
      tgt       <= '0;
      shift_r   <= '0;
      div_r     <= '0;
      cnt       <= '0;
      settled   <= 1'b0;
    end else begin
      settled <= 1'b0;
      if (accept) begin
        // Frequency is left where it is; LOAD re-evaluates against the new target.
        tgt     <= target_freq;
        shift_r <= glide_shift;
        div_r   <= glide_div;
      end else begin
        case (state)
          LOAD: begin
            cnt <= '0;
            if (frequency == tgt) settled <= 1'b1;
          end
          GLIDE: begin
            if (!hold) begin
              if (cnt == div_r) begin
                frequency <= next_freq;
                cnt       <= '0;
                if (arrive) settled <= 1'b1;
              end else begin
                cnt <= cnt + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frequency_glide.sv
// Bench for frequency_glide: directed targets with hand-computed frequency
// sequences and update cycles queued as expectations; a negedge monitor
// pops and checks whenever frequency changes or settled pulses.
module tb_frequency_glide;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        target_valid = 1'b0;
  logic [23:0] target_freq = '0;
  logic [3:0]  glide_shift = '0;
  logic [7:0]  glide_div = '0;
  logic        hold = 1'b0;
  logic        target_ready;
  logic [23:0] frequency;
  logic        gliding;
  logic        settled;

  typedef struct {
    logic [23:0] val;
    int          at;
  } exp_t;

  exp_t        fq[$];
  exp_t        sq[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [23:0] last_freq = '0;

  frequency_glide #(.FREQ_W(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .target_valid (target_valid),
    .target_freq  (target_freq),
    .target_ready (target_ready),
    .glide_shift  (glide_shift),
    .glide_div    (glide_div),
    .hold         (hold),
    .frequency    (frequency),
    .gliding      (gliding),
    .settled      (settled)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_f(input logic [23:0] v, input int at);
    exp_t e;
    e.val = v;
    e.at  = at;
    fq.push_back(e);
  endtask

  task automatic push_s(input logic [23:0] v, input int at);
    exp_t e;
    e.val = v;
    e.at  = at;
    sq.push_back(e);
  endtask

  // Monitor: every frequency change and settled pulse must be expected.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_freq = frequency;
    end else begin
      if (frequency !== last_freq) begin
        if (fq.size() == 0) begin
          chk("unexpected_freq_change", {8'h0, frequency}, {8'h0, last_freq});
        end else begin
          e = fq.pop_front();
          chk("freq_value", {8'h0, frequency}, {8'h0, e.val});
          chk("freq_cycle", cyc, e.at);
        end
        last_freq = frequency;
      end
      if (settled) begin
        if (sq.size() == 0) begin
          chk("unexpected_settled", 1, 0);
        end else begin
          e = sq.pop_front();
          chk("settled_freq", {8'h0, frequency}, {8'h0, e.val});
          chk("settled_cycle", cyc, e.at);
        end
      end
    end
  end

  // Offer a target and return the cycle index of the accepting edge. The
  // config inputs are scrambled afterwards; the DUT must have latched them.
  task automatic accept(input logic [23:0] f, input logic [3:0] s, input logic [7:0] d,
                        output int a);
    int w = 0;
    target_freq  = f;
    glide_shift  = s;
    glide_div    = d;
    target_valid = 1'b1;
    while (!target_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("ready_before_accept", target_ready, 1);
    @(posedge clk); #1;
    a            = cyc;
    target_valid = 1'b0;
    glide_shift  = 4'hF;
    glide_div    = 8'hFF;
    target_freq  = 24'hABCDEF;
  endtask

  task automatic drain(input int budget);
    int w = 0;
    while ((fq.size() != 0 || sq.size() != 0) && w < budget) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (2) begin @(posedge clk); #1; end
    chk("drain_freq_queue", fq.size(), 0);
    chk("drain_settled_queue", sq.size(), 0);
  endtask

  initial begin
    int a;
    int b;
    logic [23:0] up_vals [5];
    logic [23:0] dn_vals [10];
    up_vals = '{24'h8, 24'hC, 24'hE, 24'hF, 24'h10};
    dn_vals = '{24'd12, 24'd9, 24'd7, 24'd6, 24'd5, 24'd4, 24'd3, 24'd2, 24'd1, 24'd0};

    // Reset held for 5 clocks.
    rst = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("reset_frequency", {8'h0, frequency}, 32'h0);
    chk("reset_gliding", gliding, 0);
    chk("reset_settled", settled, 0);
    chk("reset_ready", target_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", target_ready, 1);

    // Jump: shift 0, div 0 -> target reached two edges after acceptance.
    accept(24'h024000, 4'd0, 8'd0, a);
    push_f(24'h024000, a + 2);
    push_s(24'h024000, a + 2);
    drain(20);
    chk("jump_gliding_after", gliding, 0);
    chk("jump_frequency_after", {8'h0, frequency}, 32'h024000);

    // Jump back to 0.
    accept(24'h0, 4'd0, 8'd0, a);
    push_f(24'h0, a + 2);
    push_s(24'h0, a + 2);
    drain(20);

    // Upward glide, shift 1, div 0: one update per clock.
    accept(24'h10, 4'd1, 8'd0, a);
    for (int k = 0; k < 5; k++) push_f(up_vals[k], a + 2 + k);
    push_s(24'h10, a + 6);
    drain(30);
    chk("up_gliding_after", gliding, 0);

    // Downward glide, shift 2, div 3: updates every 4 clocks, no underflow.
    accept(24'h0, 4'd2, 8'd3, a);
    for (int k = 0; k < 10; k++) push_f(dn_vals[k], a + 5 + 4 * k);
    push_s(24'h0, a + 41);
    drain(100);
    chk("down_frequency_after", {8'h0, frequency}, 32'h0);

    // Hold mid-glide for 10 clocks, then retarget to the current value.
    accept(24'h40, 4'd1, 8'd1, a);
    push_f(24'd32, a + 3);
    push_f(24'd48, a + 5);
    repeat (5) begin @(posedge clk); #1; end
    hold = 1'b1;
    repeat (9) begin @(posedge clk); #1; end
    chk("hold_frequency", {8'h0, frequency}, 32'd48);
    chk("hold_gliding", gliding, 1);
    accept(24'd48, 4'd3, 8'd5, b);
    chk("retarget_edge", b, a + 15);
    hold = 1'b0;
    #1;
    chk("retarget_load_ready", target_ready, 0);
    push_s(24'd48, b + 1);
    drain(30);
    chk("retarget_frequency", {8'h0, frequency}, 32'd48);
    chk("retarget_gliding", gliding, 0);

    // Reset in the middle of a glide.
    accept(24'h1000, 4'd4, 8'd2, a);
    push_f(24'h12D, a + 4);
    repeat (6) begin @(posedge clk); #1; end
    chk("midglide_gliding", gliding, 1);
    rst = 1'b1;
    #1;
    chk("midreset_frequency", {8'h0, frequency}, 32'h0);
    chk("midreset_gliding", gliding, 0);
    chk("midreset_ready", target_ready, 0);
    chk("midreset_settled", settled, 0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk("ready_after_midreset", target_ready, 1);
    repeat (20) begin @(posedge clk); #1; end
    chk("post_reset_frequency", {8'h0, frequency}, 32'h0);
    chk("post_reset_gliding", gliding, 0);
    chk("post_reset_freq_queue", fq.size(), 0);
    chk("post_reset_settled_queue", sq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
